// File: rtl/timer_tick_master.sv
// Avalon-MM initiator servicing a 16-bit interval timer: enables its IRQ, reads and clears the
// status on each timeout, and turns every serviced timeout into a one-cycle tick plus a count.
module timer_tick_master #(
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              irq,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              spurious,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StInitWr,
        StWaitIrq,
        StRdAddr,
        StRdCap,
        StClrWr,
        StDisWr
    } state_e;

    localparam logic [2:0]  AddrStatus  = 3'd0;
    localparam logic [2:0]  AddrControl = 3'd1;
    localparam logic [15:0] CtrlIto     = 16'h0001;

    state_e              state_q;
    logic [2:0]          addr_q;
    logic                cs_q;
    logic                wr_n_q;
    logic [15:0]         wdata_q;
    logic                tick_q;
    logic [TICK_W-1:0]   cnt_q;
    logic                spur_q;
    logic                busy_q;

    // Only the TO flag of the status word matters here.
    logic unused_rdata;
    assign unused_rdata = ^m_readdata[15:1];

    // Bus outputs are registered alongside the state, so they always describe the state held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= AddrStatus;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            addr_q  <= AddrStatus;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StInitWr;
                        addr_q  <= AddrControl;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        wdata_q <= CtrlIto;
                        cnt_q   <= '0;
                        spur_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StInitWr: begin
                    state_q <= StWaitIrq;
                end
                StWaitIrq: begin
                    if (!enable) begin
                        state_q <= StDisWr;
                        addr_q  <= AddrControl;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (irq) begin
                        state_q <= StRdAddr;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StRdAddr: begin
                    state_q <= StRdCap;
                    cs_q    <= 1'b1;
                    busy_q  <= 1'b1;
                end
                StRdCap: begin
                    if (m_readdata[0]) begin
                        state_q <= StClrWr;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        tick_q  <= 1'b1;
                        cnt_q   <= cnt_q + TICK_W'(1);
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StWaitIrq;
                        spur_q  <= 1'b1;
                    end
                end
                StClrWr: begin
                    state_q <= StWaitIrq;
                end
                StDisWr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wr_n_q;
    assign m_writedata  = wdata_q;
    assign tick         = tick_q;
    assign tick_count   = cnt_q;
    assign spurious     = spur_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master: behavioural timer slave, cycle-exact directed checks and a
// randomized phase scored against a transaction-level model of writes and tick counts.
module tb_timer_tick_master;

    localparam int unsigned TW   = 5;
    localparam int unsigned CMOD = 1 << TW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          irq;
    logic [2:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [15:0]   m_writedata;
    logic [15:0]   m_readdata;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          spurious;
    logic          busy;

    logic          to_q      = 1'b0;
    logic          ito_q     = 1'b0;
    logic [15:0]   rdata_q   = '0;
    logic          timeout   = 1'b0;
    logic          force_irq = 1'b0;
    logic          tick_prev = 1'b0;

    logic [18:0]   wr_log[$];
    logic [18:0]   exp_wr[$];
    int            total      = 0;
    int            bad        = 0;
    int            tick_seen  = 0;
    int            exp_ticks  = 0;

    timer_tick_master #(.TICK_W(TW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .irq          (irq),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .tick         (tick),
        .tick_count   (tick_count),
        .spurious     (spurious),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign irq        = (to_q && ito_q) || force_irq;
    assign m_readdata = rdata_q;

    // Interval-timer slave; a status write wins over a same-edge timeout.
    always @(posedge clk) begin
        if (m_chipselect && !m_write_n) begin
            wr_log.push_back({m_address, m_writedata});
            if (m_address == 3'd0) to_q <= 1'b0;
            else if (timeout) to_q <= 1'b1;
            if (m_address == 3'd1) ito_q <= m_writedata[0];
        end else if (timeout) begin
            to_q <= 1'b1;
        end
        if (m_chipselect && m_write_n)
            rdata_q <= (m_address == 3'd0) ? {15'd0, to_q} : {15'd0, ito_q};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("tick_twice", {31'd0, tick & tick_prev}, 32'd0);
        check("addr_range", {31'd0, m_chipselect && (m_address > 3'd1)}, 32'd0);
        tick_prev = tick;
        if (tick) tick_seen++;
    end

    task automatic do_timeout(input int unsigned gap);
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_cs"}, {31'd0, m_chipselect}, 32'd0);
        check({tag, "_wn"}, {31'd0, m_write_n}, 32'd1);
        check({tag, "_addr"}, {29'd0, m_address}, 32'd0);
        check({tag, "_wd"}, {16'd0, m_writedata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_cnt;
        int unsigned gap;
        int unsigned r;
        bit          en_m;
        bit          pending;
        int          n;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_bus("rst");
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_cnt", {27'd0, tick_count}, 32'd0);
        check("rst_spur", {31'd0, spurious}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_cs", {31'd0, m_chipselect}, 32'd0);

        // Enable: one control write of ITO=1, then a quiet bus in WAIT_IRQ.
        enable = 1'b1;
        exp_wr.push_back({3'd1, 16'h0001});
        @(negedge clk);
        check("init_cs", {31'd0, m_chipselect}, 32'd1);
        check("init_wn", {31'd0, m_write_n}, 32'd0);
        check("init_addr", {29'd0, m_address}, 32'd1);
        check("init_wd", {16'd0, m_writedata}, 32'h0001);
        check("init_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_idle_bus("wait");
        check("wait_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("init_nwr", wr_log.size(), 32'd1);

        // One timeout, cycle-exact service.
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        check("t0_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("t1_cs", {31'd0, m_chipselect}, 32'd1);
        check("t1_wn", {31'd0, m_write_n}, 32'd1);
        check("t1_addr", {29'd0, m_address}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t2_cs", {31'd0, m_chipselect}, 32'd1);
        check("t2_wn", {31'd0, m_write_n}, 32'd1);
        check("t2_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        check("t3_tick", {31'd0, tick}, 32'd1);
        check("t3_wn", {31'd0, m_write_n}, 32'd0);
        check("t3_addr", {29'd0, m_address}, 32'd0);
        check("t3_wd", {16'd0, m_writedata}, 32'd0);
        exp_wr.push_back({3'd0, 16'h0000});
        exp_ticks++;
        @(negedge clk);
        check("t4_irq", {31'd0, irq}, 32'd0);
        check("t4_tick", {31'd0, tick}, 32'd0);
        check("t4_cnt", {27'd0, tick_count}, 32'd1);

        // Spurious IRQ: read only, no clear, no tick.
        repeat (2) @(negedge clk);
        force_irq = 1'b1;
        @(negedge clk);
        force_irq = 1'b0;
        check("sp1_cs", {31'd0, m_chipselect}, 32'd1);
        repeat (2) @(negedge clk);
        check("sp_flag", {31'd0, spurious}, 32'd1);
        check("sp_tick", {31'd0, tick}, 32'd0);
        check("sp_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("sp_cnt", {27'd0, tick_count}, 32'd1);
        check("sp_nwr", wr_log.size(), exp_wr.size());

        // Drop enable during RD_CAP: the clear completes before the disable write.
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis3_tick", {31'd0, tick}, 32'd1);
        check("dis3_wn", {31'd0, m_write_n}, 32'd0);
        check("dis3_addr", {29'd0, m_address}, 32'd0);
        exp_wr.push_back({3'd0, 16'h0000});
        exp_ticks++;
        @(negedge clk);
        check("dis4_cs", {31'd0, m_chipselect}, 32'd0);
        @(negedge clk);
        check("dis5_cs", {31'd0, m_chipselect}, 32'd1);
        check("dis5_wn", {31'd0, m_write_n}, 32'd0);
        check("dis5_addr", {29'd0, m_address}, 32'd1);
        check("dis5_wd", {16'd0, m_writedata}, 32'd0);
        exp_wr.push_back({3'd1, 16'h0000});
        @(negedge clk);
        check_idle_bus("dis6");
        check("dis6_busy", {31'd0, busy}, 32'd0);
        check("dis6_cnt", {27'd0, tick_count}, 32'd2);
        check("dis6_spur", {31'd0, spurious}, 32'd1);
        repeat (5) @(negedge clk);
        check("dis_nwr", wr_log.size(), exp_wr.size());

        // Re-enable clears count and spurious; then reset lands during CLR_WR.
        enable = 1'b1;
        exp_wr.push_back({3'd1, 16'h0001});
        @(negedge clk);
        check("re_spur", {31'd0, spurious}, 32'd0);
        check("re_cnt", {27'd0, tick_count}, 32'd0);
        repeat (2) @(negedge clk);
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        repeat (3) @(negedge clk);
        check("rc_tick", {31'd0, tick}, 32'd1);
        exp_ticks++;
        #2 reset_n = 1'b0;
        #1;
        check_idle_bus("rc");
        check("rc_tick0", {31'd0, tick}, 32'd0);
        check("rc_cnt", {27'd0, tick_count}, 32'd0);
        check("rc_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("rc_pend", {31'd0, to_q}, 32'd1);
        exp_wr.push_back({3'd1, 16'h0001});
        exp_wr.push_back({3'd0, 16'h0000});
        exp_ticks++;
        repeat (8) @(negedge clk);
        check("rc_cnt1", {27'd0, tick_count}, 32'd1);
        check("rc_to", {31'd0, to_q}, 32'd0);

        // Run the counter to all-ones, then wrap.
        for (int i = 0; i < int'(CMOD) - 2; i++) begin
            exp_wr.push_back({3'd0, 16'h0000});
            exp_ticks++;
            do_timeout(5);
        end
        check("wrap_max", {27'd0, tick_count}, CMOD - 1);
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_tick", {31'd0, tick}, 32'd1);
        exp_wr.push_back({3'd0, 16'h0000});
        exp_ticks++;
        @(negedge clk);
        check("wrap_cnt", {27'd0, tick_count}, 32'd0);
        repeat (2) @(negedge clk);

        // Random timeouts and enable toggles against a transaction-level model.
        exp_cnt = 0;
        en_m    = 1'b1;
        pending = 1'b0;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                if (en_m) begin
                    exp_cnt = (exp_cnt + 1) % CMOD;
                    exp_ticks++;
                    exp_wr.push_back({3'd0, 16'h0000});
                end else begin
                    pending = 1'b1;
                end
                gap = $urandom_range(5, 9);
                do_timeout(gap);
            end else begin
                if (en_m) begin
                    enable = 1'b0;
                    exp_wr.push_back({3'd1, 16'h0000});
                    en_m = 1'b0;
                end else begin
                    enable = 1'b1;
                    exp_wr.push_back({3'd1, 16'h0001});
                    exp_cnt = 0;
                    if (pending) begin
                        exp_cnt = 1;
                        exp_ticks++;
                        exp_wr.push_back({3'd0, 16'h0000});
                        pending = 1'b0;
                    end
                    en_m = 1'b1;
                end
                gap = $urandom_range(8, 12);
                repeat (gap) @(negedge clk);
            end
            check("rand_cnt", {27'd0, tick_count}, exp_cnt);
        end

        repeat (4) @(negedge clk);
        check("tick_total", tick_seen, exp_ticks);
        check("wr_count", wr_log.size(), exp_wr.size());
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr", {29'd0, wr_log[i][18:16]}, {29'd0, exp_wr[i][18:16]});
            check("wr_data", {16'd0, wr_log[i][15:0]}, {16'd0, exp_wr[i][15:0]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
